// File: rtl/sblk_row_skew_drain.sv
// sblk_row_skew_drain: per-column skewed control fan-out plus a serialising psum drain engine.
module sblk_row_skew_drain #(
  parameter int N_COLUMN     = 4,
  parameter int WID_CTRL     = 64,
  parameter int SKEW         = 1,
  parameter int WID_PSUM     = 32,
  parameter int WID_PSUMADDR = 9,
  parameter int RD_LAT       = 2,
  parameter int WID_COL      = (N_COLUMN > 1) ? $clog2(N_COLUMN) : 1
) (
  input  logic                               clk_l,
  input  logic                               rst,
  input  logic [WID_CTRL-1:0]                ctrl_in,
  input  logic                               ctrl_in_vld,
  input  logic [N_COLUMN-1:0]                col_en,
  output logic [N_COLUMN*WID_CTRL-1:0]       ctrl_out,
  output logic [N_COLUMN-1:0]                ctrl_out_vld,
  input  logic                               drain_start,
  input  logic [WID_PSUMADDR-1:0]            drain_base,
  input  logic [WID_PSUMADDR:0]              drain_len,
  output logic                               drain_busy,
  output logic                               drain_done,
  output logic [N_COLUMN-1:0]                psum_rd_en,
  output logic [WID_PSUMADDR-1:0]            psum_rd_addr,
  input  logic [2*WID_PSUM*N_COLUMN-1:0]     psum_rd_data,
  output logic [2*WID_PSUM-1:0]              out_data,
  output logic [WID_COL-1:0]                 out_col,
  output logic                               out_vld,
  input  logic                               out_rdy,
  output logic                               out_last
);
  localparam int NSTG = (N_COLUMN > 1) ? (N_COLUMN - 1) * SKEW : 1;
  localparam int PW = 2 * WID_PSUM;
  localparam int WID_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WID_PSUMADDR:0] REM_ONE = 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SEND, DONE} state_t;
  logic [WID_CTRL:0] stg_q [NSTG];
  logic [WID_CTRL:0] tap [N_COLUMN];
  logic [N_COLUMN*WID_CTRL-1:0] ctrl_q;
  logic [N_COLUMN-1:0] cvld_q;
  state_t state_q, state_d;
  logic [WID_PSUMADDR-1:0] addr_q, addr_d;
  logic [WID_PSUMADDR:0] rem_q, rem_d;
  logic [WID_COL-1:0] col_q, col_d, hi_col;
  logic [N_COLUMN-1:0] mask_q, mask_d;
  logic [WID_W-1:0] wcnt_q, wcnt_d;
  logic [PW-1:0] data_q, data_d;
  logic nil_q, nil_d, hi_ok;

  function automatic logic [WID_COL-1:0] lowest(input logic [N_COLUMN-1:0] m);
    lowest = '0;
    for (int i = N_COLUMN - 1; i >= 0; i--)
      if (m[i]) lowest = WID_COL'(i);
  endfunction

  // Tap c sees the input c*SKEW cycles late; the output register adds the final cycle.
  for (genvar c = 0; c < N_COLUMN; c++) begin : g_tap
    if (c == 0) begin : g_first
      assign tap[c] = {ctrl_in, ctrl_in_vld};
    end else begin : g_rest
      assign tap[c] = stg_q[c*SKEW-1];
    end
  end

  always_ff @(posedge clk_l or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NSTG; i++) stg_q[i] <= '0;
      ctrl_q <= '0;
      cvld_q <= '0;
    end else begin
      stg_q[0] <= {ctrl_in, ctrl_in_vld};
      for (int i = 1; i < NSTG; i++) stg_q[i] <= stg_q[i-1];
      for (int c = 0; c < N_COLUMN; c++) begin
        cvld_q[c] <= col_en[c] & tap[c][0];
        if (col_en[c]) ctrl_q[c*WID_CTRL +: WID_CTRL] <= tap[c][WID_CTRL:1];
      end
    end
  end

  assign ctrl_out = ctrl_q;
  assign ctrl_out_vld = cvld_q;

  always_ff @(posedge clk_l or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      col_q   <= '0;
      mask_q  <= '0;
      wcnt_q  <= '0;
      data_q  <= '0;
      nil_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      col_q   <= col_d;
      mask_q  <= mask_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
      nil_q   <= nil_d;
    end
  end

  // Next enabled column strictly above the current one.
  always_comb begin
    hi_ok = 1'b0;
    hi_col = '0;
    for (int i = N_COLUMN - 1; i >= 0; i--)
      if (mask_q[i] && i > int'(col_q)) begin
        hi_ok = 1'b1;
        hi_col = WID_COL'(i);
      end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    col_d   = col_q;
    mask_d  = mask_q;
    wcnt_d  = wcnt_q;
    data_d  = data_q;
    nil_d   = nil_q;
    case (state_q)
      IDLE: if (drain_start) begin
        mask_d = col_en;
        if (drain_len != '0 && col_en != '0) begin
          addr_d  = drain_base;
          rem_d   = drain_len;
          col_d   = lowest(col_en);
          nil_d   = 1'b0;
          state_d = ISSUE;
        end else begin
          nil_d   = 1'b1;
          state_d = DONE;
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: if (wcnt_q == WID_W'(RD_LAT - 1)) begin
        data_d  = psum_rd_data[int'(col_q)*PW +: PW];
        state_d = SEND;
      end else begin
        wcnt_d = wcnt_q + WID_W'(1);
      end
      SEND: if (out_rdy) begin
        if (hi_ok) begin
          col_d   = hi_col;
          state_d = ISSUE;
        end else if (rem_q == REM_ONE) begin
          state_d = DONE;
        end else begin
          col_d   = lowest(mask_q);
          addr_d  = addr_q + WID_PSUMADDR'(1);
          rem_d   = rem_q - REM_ONE;
          state_d = ISSUE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A zero-length drain reports busy during its single DONE cycle.
  always_comb begin
    drain_busy   = (state_q inside {ISSUE, WAIT, SEND}) || (state_q == DONE && nil_q);
    drain_done   = state_q == DONE;
    psum_rd_en   = (state_q == ISSUE) ? N_COLUMN'(1) << col_q : '0;
    psum_rd_addr = addr_q;
    out_data     = data_q;
    out_col      = col_q;
    out_vld      = state_q == SEND;
    out_last     = state_q == SEND && !hi_ok && rem_q == REM_ONE;
  end
endmodule

// File: tb/tb_sblk_row_skew_drain.sv
// tb_sblk_row_skew_drain: randomized bench for the skew chain and psum drain against a queue-based model.
module tb_sblk_row_skew_drain;
  localparam int N = 4, WC = 16, SK = 2, WP = 16, WA = 9, RL = 2, WCOL = 2;
  logic clk_l = 1'b0, rst = 1'b1;
  logic [WC-1:0] ctrl_in = '0;
  logic ctrl_in_vld = 1'b0;
  logic [N-1:0] col_en = '0;
  logic [N*WC-1:0] ctrl_out;
  logic [N-1:0] ctrl_out_vld;
  logic drain_start = 1'b0;
  logic [WA-1:0] drain_base = '0;
  logic [WA:0] drain_len = '0;
  logic drain_busy, drain_done;
  logic [N-1:0] psum_rd_en;
  logic [WA-1:0] psum_rd_addr;
  logic [2*WP*N-1:0] psum_rd_data;
  logic [2*WP-1:0] out_data;
  logic [WCOL-1:0] out_col;
  logic out_vld, out_last;
  logic out_rdy = 1'b0;
  int total = 0, bad = 0;
  logic [7:0] salt = 8'h11;
  logic [N-1:0] pe [RL] = '{default: '0};
  logic [WA-1:0] pa [RL] = '{default: '0};

  sblk_row_skew_drain #(.N_COLUMN(N), .WID_CTRL(WC), .SKEW(SK), .WID_PSUM(WP),
                        .WID_PSUMADDR(WA), .RD_LAT(RL)) dut (
    .clk_l(clk_l), .rst(rst), .ctrl_in(ctrl_in), .ctrl_in_vld(ctrl_in_vld), .col_en(col_en),
    .ctrl_out(ctrl_out), .ctrl_out_vld(ctrl_out_vld), .drain_start(drain_start),
    .drain_base(drain_base), .drain_len(drain_len), .drain_busy(drain_busy),
    .drain_done(drain_done), .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr),
    .psum_rd_data(psum_rd_data), .out_data(out_data), .out_col(out_col), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_last(out_last));

  always #5 clk_l = ~clk_l;

  // Column memories: data is valid only on the cycle exactly RL cycles after the strobe.
  always @(posedge clk_l) begin
    pe[0] <= psum_rd_en;
    pa[0] <= psum_rd_addr;
    for (int i = 1; i < RL; i++) begin
      pe[i] <= pe[i-1];
      pa[i] <= pa[i-1];
    end
  end

  always_comb begin
    psum_rd_data = '0;
    for (int c = 0; c < N; c++)
      psum_rd_data[c*2*WP +: 2*WP] = pe[RL-1][c] ? {salt, 6'b0, WCOL'(c), 7'b0, pa[RL-1]} : 32'hEEEE_EEEE;
  end

  function automatic logic [2*WP-1:0] exp_word(input logic [WCOL-1:0] c, input logic [WA-1:0] a);
    exp_word = {salt, 6'b0, c, 7'b0, a};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    drain_start = 1'b0;
    out_rdy = 1'b0;
    ctrl_in = '0;
    ctrl_in_vld = 1'b0;
    @(negedge clk_l);
    @(negedge clk_l);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ctrl_in = WC'($urandom);
    ctrl_in_vld = 1'b1;
    col_en = '1;
    drain_start = 1'b1;
    drain_len = 3;
    out_rdy = 1'b1;
    repeat (3) @(negedge clk_l);
    total++;
    if ({ctrl_out, ctrl_out_vld} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got %h/%b want 0", ctrl_out, ctrl_out_vld);
    end
    total++;
    if ({drain_busy, drain_done, psum_rd_en, psum_rd_addr, out_data, out_col, out_vld, out_last} !== '0) begin
      bad++;
      $display("FAIL reset_drain: busy=%b done=%b en=%b addr=%0d data=%h col=%0d vld=%b last=%b want all 0",
               drain_busy, drain_done, psum_rd_en, psum_rd_addr, out_data, out_col, out_vld, out_last);
    end
    do_reset();
  endtask

  // mode 0: single 0xA5 pulse, all columns; mode 1: stream then mask 0101; mode 2: fully random.
  task automatic run_skew(input int ncyc, input int mode);
    logic [WC-1:0] hd[$];
    logic hv[$];
    logic [N-1:0] he[$];
    logic [WC-1:0] ed [N];
    logic [N-1:0] ev;
    logic [N*WC-1:0] eo;
    int idx;
    do_reset();
    for (int c = 0; c < N; c++) ed[c] = '0;
    for (int m = 0; m <= ncyc; m++) begin
      if (m > 0) begin
        @(negedge clk_l);
        ev = '0;
        for (int c = 0; c < N; c++) begin
          idx = m - 1 - SK * c;
          if (he[m-1][c]) begin
            ev[c] = (idx >= 0) ? hv[idx] : 1'b0;
            ed[c] = (idx >= 0) ? hd[idx] : '0;
          end
          eo[c*WC +: WC] = ed[c];
        end
        total++;
        if (ctrl_out_vld !== ev) begin
          bad++;
          $display("FAIL skew_vld mode%0d cyc%0d: got %b want %b", mode, m, ctrl_out_vld, ev);
        end
        total++;
        if (ctrl_out !== eo) begin
          bad++;
          $display("FAIL skew_data mode%0d cyc%0d: got %h want %h", mode, m, ctrl_out, eo);
        end
      end
      if (mode == 0) begin
        col_en = '1;
        ctrl_in_vld = (m == 0);
        ctrl_in = (m == 0) ? WC'(16'h00A5) : WC'($urandom);
      end else if (mode == 1) begin
        col_en = (m < 8) ? 4'b1111 : 4'b0101;
        ctrl_in_vld = 1'b1;
        ctrl_in = WC'($urandom);
      end else begin
        if (m % 7 == 0) col_en = N'($urandom);
        ctrl_in_vld = 1'($urandom_range(1));
        ctrl_in = WC'($urandom);
      end
      hd.push_back(ctrl_in);
      hv.push_back(ctrl_in_vld);
      he.push_back(col_en);
    end
    ctrl_in_vld = 1'b0;
  endtask

  task automatic test_skew();
    run_skew(12, 0);
    run_skew(30, 1);
    run_skew(60, 2);
  endtask

  task automatic run_drain(input logic [WA-1:0] base, input int len, input logic [N-1:0] mask,
                           input int pct, input bit extra);
    logic [WCOL+WA-1:0] q[$];
    logic [WCOL+WA-1:0] e;
    logic [2*WP-1:0] hd;
    logic [WCOL-1:0] hc;
    logic hl;
    bit hold = 0, fin = 0;
    int beats = 0, prev = -1, nexp;
    for (int a = 0; a < len; a++)
      for (int c = 0; c < N; c++)
        if (mask[c]) q.push_back({WCOL'(c), WA'(int'(base) + a)});
    nexp = q.size();
    salt = 8'($urandom_range(200));
    col_en = mask;
    drain_base = base;
    drain_len = (WA+1)'(len);
    drain_start = 1'b1;
    out_rdy = 1'b0;
    @(negedge clk_l);
    drain_start = 1'b0;
    total++;
    if (drain_busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_start: got %b want 1", drain_busy);
    end
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (psum_rd_en !== '0) begin
        total++;
        if ((psum_rd_en & ~mask) !== '0 || $countones(psum_rd_en) != 1) begin
          bad++;
          $display("FAIL rd_en: got %b with mask %b, want one-hot enabled", psum_rd_en, mask);
        end
      end
      if (hold) begin
        total++;
        if (out_vld !== 1'b1 || out_data !== hd || out_col !== hc || out_last !== hl) begin
          bad++;
          $display("FAIL stall: got vld=%b data=%h col=%0d last=%b want 1/%h/%0d/%b",
                   out_vld, out_data, out_col, out_last, hd, hc, hl);
        end
      end
      if (drain_done) begin
        total++;
        if (q.size() != 0 || drain_busy !== 1'b0 || out_vld !== 1'b0) begin
          bad++;
          $display("FAIL done: got left=%0d busy=%b vld=%b want 0/0/0", q.size(), drain_busy, out_vld);
        end
        fin = 1;
      end else begin
        if (extra) begin
          drain_start = (cyc == 4);
          if (cyc == 4) begin
            drain_base = base + 9'd7;
            drain_len = 3;
          end
        end
        out_rdy = ($urandom_range(99) < pct);
        if (out_vld && out_rdy) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL extra_beat: got col=%0d data=%h want no beat", out_col, out_data);
          end else begin
            e = q.pop_front();
            if (out_col !== e[WA +: WCOL] || out_data !== exp_word(e[WA +: WCOL], e[WA-1:0]) ||
                out_last !== (q.size() == 0)) begin
              bad++;
              $display("FAIL beat: got col=%0d data=%h last=%b want col=%0d data=%h last=%b",
                       out_col, out_data, out_last, e[WA +: WCOL], exp_word(e[WA +: WCOL], e[WA-1:0]),
                       q.size() == 0);
            end
            if (pct == 100 && prev >= 0) begin
              total++;
              if (cyc - prev != RL + 2) begin
                bad++;
                $display("FAIL gap: got %0d cycles want %0d", cyc - prev, RL + 2);
              end
            end
            prev = cyc;
            beats++;
          end
          hold = 0;
        end else begin
          hold = out_vld;
          hd = out_data;
          hc = out_col;
          hl = out_last;
        end
        @(negedge clk_l);
      end
    end
    drain_start = 1'b0;
    out_rdy = 1'b0;
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL timeout: got no drain_done want done");
    end
    total++;
    if (beats != nexp) begin
      bad++;
      $display("FAIL beat_count: got %0d want %0d", beats, nexp);
    end
    @(negedge clk_l);
    total++;
    if (drain_done !== 1'b0 || drain_busy !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: got done=%b busy=%b want 0/0", drain_done, drain_busy);
    end
  endtask

  task automatic test_drain_order();
    run_drain(9'd5, 2, 4'b1011, 100, 1'b0);
  endtask

  task automatic test_wrap();
    run_drain(9'd511, 2, 4'b1111, 100, 1'b0);
    run_drain(9'd510, 3, 4'b0100, 60, 1'b0);
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 6; k++)
      run_drain(WA'($urandom), $urandom_range(1, 4), N'($urandom_range(1, 15)), 30, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_drain(9'd100, 2, 4'b0110, 100, 1'b1);
    run_drain(9'd200, 1, 4'b1000, 50, 1'b1);
  endtask

  task automatic test_zero();
    for (int k = 0; k < 2; k++) begin
      col_en = (k == 0) ? 4'b1111 : 4'b0000;
      drain_len = (k == 0) ? 0 : 5;
      drain_base = 9'd9;
      drain_start = 1'b1;
      out_rdy = 1'b1;
      @(negedge clk_l);
      drain_start = 1'b0;
      total++;
      if (drain_busy !== 1'b1 || drain_done !== 1'b1 || out_vld !== 1'b0 || psum_rd_en !== '0) begin
        bad++;
        $display("FAIL zero%0d: got busy=%b done=%b vld=%b en=%b want 1/1/0/0",
                 k, drain_busy, drain_done, out_vld, psum_rd_en);
      end
      @(negedge clk_l);
      total++;
      if (drain_busy !== 1'b0 || drain_done !== 1'b0 || out_vld !== 1'b0) begin
        bad++;
        $display("FAIL zero_after%0d: got busy=%b done=%b vld=%b want 0/0/0", k, drain_busy, drain_done, out_vld);
      end
    end
    out_rdy = 1'b0;
  endtask

  task automatic test_rst_mid_send();
    bit seen = 0, leak = 0;
    col_en = '1;
    drain_base = 9'd3;
    drain_len = 2;
    drain_start = 1'b1;
    out_rdy = 1'b0;
    ctrl_in_vld = 1'b1;
    ctrl_in = WC'($urandom);
    @(negedge clk_l);
    drain_start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (out_vld) seen = 1;
      else @(negedge clk_l);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL send_wait: got no out_vld want out_vld");
    end
    rst = 1'b1;
    ctrl_in_vld = 1'b0;
    #1;
    total++;
    if ({ctrl_out, ctrl_out_vld, drain_busy, drain_done, psum_rd_en, psum_rd_addr,
         out_data, out_col, out_vld, out_last} !== '0) begin
      bad++;
      $display("FAIL rst_mid: got busy=%b done=%b vld=%b data=%h cvld=%b want all 0",
               drain_busy, drain_done, out_vld, out_data, ctrl_out_vld);
    end
    @(negedge clk_l);
    @(negedge clk_l);
    rst = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (drain_done || out_vld || drain_busy) leak = 1;
      @(negedge clk_l);
    end
    out_rdy = 1'b0;
    total++;
    if (leak) begin
      bad++;
      $display("FAIL rst_abort: got activity after reset want none");
    end
  endtask

  initial begin
    test_reset();
    test_skew();
    test_drain_order();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_zero();
    test_rst_mid_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
